// File: rtl/cfg_sync_bank.sv
// Purpose  : receive-side synchronizer bank: level bits, toggle events to pulses, stability-qualified config bus.
// Latency  : lvl SYNC_STAGES edges; tgl pulse SYNC_STAGES+1 edges; bus SYNC_STAGES+STABLE_CYCLES+2 edges.
// Backpres.: none; i_bus_hold freezes o_bus_out while qualification keeps tracking the input.
//
// Ports:
//   i_pktctrl_clk   clock for the whole block
//   i_pktctrl_rstn  synchronous active-low reset
//   i_lvl_in        asynchronous level bits        -> o_lvl_sync   synchronized levels
//   i_tgl_in        asynchronous toggle bits       -> o_tgl_pulse  one-cycle event pulses
//   i_bus_in        asynchronous config bus        -> o_bus_out    qualified bus value
//   i_bus_hold      synchronous freeze of o_bus_out
//   o_bus_upd       high in the cycle o_bus_out first shows a new value
//   o_bus_busy      candidate differs from o_bus_out
module cfg_sync_bank #(
    parameter int                   NUM_LVL       = 4,
    parameter int                   NUM_TGL       = 3,
    parameter int                   BUS_WIDTH     = 16,
    parameter int                   SYNC_STAGES   = 2,
    parameter int                   STABLE_CYCLES = 4,
    parameter logic [BUS_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                 i_pktctrl_clk,
    input  logic                 i_pktctrl_rstn,
    input  logic [NUM_LVL-1:0]   i_lvl_in,
    input  logic [NUM_TGL-1:0]   i_tgl_in,
    input  logic [BUS_WIDTH-1:0] i_bus_in,
    input  logic                 i_bus_hold,
    output logic [NUM_LVL-1:0]   o_lvl_sync,
    output logic [NUM_TGL-1:0]   o_tgl_pulse,
    output logic [BUS_WIDTH-1:0] o_bus_out,
    output logic                 o_bus_upd,
    output logic                 o_bus_busy
);

    localparam logic [2:0] ARM_MAX    = 3'(SYNC_STAGES + 1);
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    // Synchronizer chains: index 0 is the first flop, SYNC_STAGES-1 the last.
    logic [SYNC_STAGES-1:0][NUM_LVL-1:0]   r_lvl_chain;
    logic [SYNC_STAGES-1:0][NUM_TGL-1:0]   r_tgl_chain;
    logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] r_bus_chain;

    logic [NUM_TGL-1:0]   r_tgl_ref;
    logic [NUM_TGL-1:0]   r_tgl_pulse;
    logic [2:0]           r_arm_cnt;

    logic [BUS_WIDTH-1:0] r_cand;
    logic [7:0]           r_cnt;
    logic [BUS_WIDTH-1:0] r_bus_out;
    logic                 r_bus_upd;

    logic [NUM_TGL-1:0]   w_tgl_s;
    logic [BUS_WIDTH-1:0] w_s_bus;
    logic                 w_armed;
    logic                 w_upd;

    assign w_tgl_s = r_tgl_chain[SYNC_STAGES-1];
    assign w_s_bus = r_bus_chain[SYNC_STAGES-1];
    assign w_armed = (r_arm_cnt == ARM_MAX);

    // Update only once the candidate has been stable long enough, actually
    // differs from what is already published, and nobody is holding the bus.
    assign w_upd = (r_cnt == STABLE_MAX) && (r_cand != r_bus_out) && !i_bus_hold;

    // ---------------------------------------------------------------- levels
    always_ff @(posedge i_pktctrl_clk) begin
        if (!i_pktctrl_rstn) begin
            r_lvl_chain <= '0;
        end else begin
            r_lvl_chain <= {r_lvl_chain[SYNC_STAGES-2:0], i_lvl_in};
        end
    end

    // --------------------------------------------------------------- toggles
    // The reference register loads every cycle, including before arming, so
    // differences seen while the chains fill up after reset are absorbed.
    always_ff @(posedge i_pktctrl_clk) begin
        if (!i_pktctrl_rstn) begin
            r_tgl_chain <= '0;
            r_tgl_ref   <= '0;
            r_tgl_pulse <= '0;
            r_arm_cnt   <= '0;
        end else begin
            r_tgl_chain <= {r_tgl_chain[SYNC_STAGES-2:0], i_tgl_in};
            r_tgl_ref   <= w_tgl_s;
            r_tgl_pulse <= {NUM_TGL{w_armed}} & (w_tgl_s ^ r_tgl_ref);
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------- bus
    // A change of the synchronized bus restarts qualification; the update
    // decision in the same cycle still uses the old candidate.
    always_ff @(posedge i_pktctrl_clk) begin
        if (!i_pktctrl_rstn) begin
            r_bus_chain <= '0;
            r_cand      <= INIT_VALUE;
            r_cnt       <= '0;
            r_bus_out   <= INIT_VALUE;
            r_bus_upd   <= 1'b0;
        end else begin
            r_bus_chain <= {r_bus_chain[SYNC_STAGES-2:0], i_bus_in};
            if (w_s_bus != r_cand) begin
                r_cand <= w_s_bus;
                r_cnt  <= '0;
            end else if (r_cnt < STABLE_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_upd) begin
                r_bus_out <= r_cand;
            end
            r_bus_upd <= w_upd;
        end
    end

    assign o_lvl_sync  = r_lvl_chain[SYNC_STAGES-1];
    assign o_tgl_pulse = r_tgl_pulse;
    assign o_bus_out   = r_bus_out;
    assign o_bus_upd   = r_bus_upd;
    assign o_bus_busy  = (r_cand != r_bus_out);

endmodule

// File: tb/tb_cfg_sync_bank.sv
// Directed bench for cfg_sync_bank: one instance with SYNC_STAGES=2 (defaults)
// and one with SYNC_STAGES=3, both driven from the same stimulus.
module tb_cfg_sync_bank;

    logic        clk;
    logic        rstn;
    logic [3:0]  lvl_in;
    logic [2:0]  tgl_in;
    logic [15:0] bus_in;
    logic        bus_hold;

    logic [3:0]  d2_lvl, d3_lvl;
    logic [2:0]  d2_tgl, d3_tgl;
    logic [15:0] d2_bus, d3_bus;
    logic        d2_upd, d3_upd;
    logic        d2_busy, d3_busy;

    int n_vec = 0;
    int n_err = 0;

    cfg_sync_bank u_dut2 (
        .i_pktctrl_clk  (clk),
        .i_pktctrl_rstn (rstn),
        .i_lvl_in       (lvl_in),
        .i_tgl_in       (tgl_in),
        .i_bus_in       (bus_in),
        .i_bus_hold     (bus_hold),
        .o_lvl_sync     (d2_lvl),
        .o_tgl_pulse    (d2_tgl),
        .o_bus_out      (d2_bus),
        .o_bus_upd      (d2_upd),
        .o_bus_busy     (d2_busy)
    );

    cfg_sync_bank #(.SYNC_STAGES(3)) u_dut3 (
        .i_pktctrl_clk  (clk),
        .i_pktctrl_rstn (rstn),
        .i_lvl_in       (lvl_in),
        .i_tgl_in       (tgl_in),
        .i_bus_in       (bus_in),
        .i_bus_hold     (bus_hold),
        .o_lvl_sync     (d3_lvl),
        .o_tgl_pulse    (d3_tgl),
        .o_bus_out      (d3_bus),
        .o_bus_upd      (d3_upd),
        .o_bus_busy     (d3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        lvl_in   = '0;
        tgl_in   = '0;
        bus_in   = '0;
        bus_hold = 1'b0;
        #1;
        repeat (3) tick();

        // Reset state
        chk("rst_lvl",  {28'd0, d2_lvl},  32'h0);
        chk("rst_tgl",  {29'd0, d2_tgl},  32'h0);
        chk("rst_bus",  {16'd0, d2_bus},  32'h0);
        chk("rst_upd",  {31'd0, d2_upd},  32'h0);
        chk("rst_busy", {31'd0, d2_busy}, 32'h0);
        chk("rst_lvl3", {28'd0, d3_lvl},  32'h0);

        rstn = 1'b1;
        repeat (4) tick();

        // Level channel: lvl_in[2] rises; S=3 on edge 3, S=2 on edge 2
        lvl_in = 4'b0100;
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("lvl3_e%0d", e), {28'd0, d3_lvl}, (e >= 3) ? 32'h4 : 32'h0);
            chk($sformatf("lvl2_e%0d", e), {28'd0, d2_lvl}, (e >= 2) ? 32'h4 : 32'h0);
        end

        // Toggle tgl_in[1] 0->1: pulse on edge 3 only (S=2)
        tgl_in = 3'b010;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("tgl_rise_e%0d", e), {29'd0, d2_tgl}, (e == 3) ? 32'h2 : 32'h0);
        end
        tick();
        // Toggle back 1->0, five cycles after the first flip
        tgl_in = 3'b000;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("tgl_fall_e%0d", e), {29'd0, d2_tgl}, (e == 3) ? 32'h2 : 32'h0);
        end

        // Bus qualification 0 -> 1234: update on edge 8, busy edges 3..7
        bus_in = 16'h1234;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("q_bus_e%0d", e),  {16'd0, d2_bus},  (e >= 8) ? 32'h1234 : 32'h0);
            chk($sformatf("q_upd_e%0d", e),  {31'd0, d2_upd},  (e == 8) ? 32'h1 : 32'h0);
            chk($sformatf("q_busy_e%0d", e), {31'd0, d2_busy}, (e >= 3 && e <= 7) ? 32'h1 : 32'h0);
        end

        // Return to 0000 before the glitch test
        bus_in = 16'h0000;
        repeat (12) tick();
        chk("ret_bus",  {16'd0, d2_bus},  32'h0);
        chk("ret_busy", {31'd0, d2_busy}, 32'h0);

        // Glitch: BEEF for 3 cycles then 0000 -> never published
        bus_in = 16'hBEEF;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 3) bus_in = 16'h0000;
            chk($sformatf("g_bus_e%0d", e),  {16'd0, d2_bus},  32'h0);
            chk($sformatf("g_upd_e%0d", e),  {31'd0, d2_upd},  32'h0);
            chk($sformatf("g_busy_e%0d", e), {31'd0, d2_busy}, (e >= 3 && e <= 5) ? 32'h1 : 32'h0);
        end

        // Hold: bus_out frozen for 20 cycles, then updates on the edge after release
        bus_hold = 1'b1;
        bus_in   = 16'h00FF;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk($sformatf("h_bus_e%0d", e), {16'd0, d2_bus}, 32'h0);
            chk($sformatf("h_upd_e%0d", e), {31'd0, d2_upd}, 32'h0);
        end
        chk("h_busy", {31'd0, d2_busy}, 32'h1);
        bus_hold = 1'b0;
        tick();
        chk("hr_bus", {16'd0, d2_bus}, 32'h00FF);
        chk("hr_upd", {31'd0, d2_upd}, 32'h1);
        tick();
        chk("hr_upd_clr", {31'd0, d2_upd},  32'h0);
        chk("hr_busy",    {31'd0, d2_busy}, 32'h0);

        // Reset mid-qualification (cnt=2 after edge 5); toggles high through reset
        bus_in = 16'h5A5A;
        repeat (5) tick();
        chk("m_bus_pre", {16'd0, d2_bus}, 32'h00FF);
        rstn   = 1'b0;
        tgl_in = 3'b111;
        tick();
        chk("m_rst_bus",  {16'd0, d2_bus},  32'h0);
        chk("m_rst_upd",  {31'd0, d2_upd},  32'h0);
        chk("m_rst_busy", {31'd0, d2_busy}, 32'h0);
        rstn = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk($sformatf("m_bus_e%0d", e),  {16'd0, d2_bus},  (e >= 8) ? 32'h5A5A : 32'h0);
            chk($sformatf("m_upd_e%0d", e),  {31'd0, d2_upd},  (e == 8) ? 32'h1 : 32'h0);
            chk($sformatf("m_tgl2_e%0d", e), {29'd0, d2_tgl},  32'h0);
            chk($sformatf("m_tgl3_e%0d", e), {29'd0, d3_tgl},  32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_sync_bank.md
# cfg_sync_bank

Parametrised receive-side synchronizer bank for the packet-control clock domain. It replaces per-signal hand-instantiated synchronizers with one block. Three input groups are handled:
- level control bits, with a configurable synchronizer depth;
- toggle-encoded events, converted to single-cycle pulses with start-up suppression;
- a multi-bit configuration bus, accepted only after it has been stable for a programmable number of cycles, with a hold input and an update strobe.

All inputs arrive asynchronously from the register-file clock domain.

## Interface
Parameters:
- NUM_LVL, 4: number of level channels (≥1).
- NUM_TGL, 3: number of toggle-event channels (≥1).
- BUS_WIDTH, 16: configuration bus width (≥1).
- SYNC_STAGES, 2: flops per synchronizer chain (2–4).
- STABLE_CYCLES, 4: consecutive stable cycles required before a bus update (1–255).
- INIT_VALUE, 0: reset value of the bus candidate and bus_out (BUS_WIDTH bits).

Ports:
- pktctrl_clk, in, 1: single clock for the whole block.
- pktctrl_rstn, in, 1: reset. Synchronous, active-low.
- lvl_in, in, NUM_LVL: asynchronous level bits.
- tgl_in, in, NUM_TGL: asynchronous toggle bits. Each change of a bit is one event.
- bus_in, in, BUS_WIDTH: asynchronous configuration bus.
- bus_hold, in, 1: synchronous. While high, bus_out is frozen.
- lvl_sync, out, NUM_LVL: synchronized level bits.
- tgl_pulse, out, NUM_TGL: one-cycle event pulses.
- bus_out, out, BUS_WIDTH: qualified bus value.
- bus_upd, out, 1: high for exactly the cycle in which bus_out first shows a new value.
- bus_busy, out, 1: high while the candidate differs from bus_out.

## Operation
- Level channels:
  - Each bit passes through a SYNC_STAGES-deep flop chain.
  - lvl_sync is the last stage of the chain.
- Toggle channels:
  - Each bit passes through a SYNC_STAGES chain, giving t_s.
  - A reference register t_r loads t_s every cycle.
  - tgl_pulse[i] = armed & (t_s[i] ^ t_r[i]), registered.
  - armed is driven by an arm counter. The counter clears on reset and counts to SYNC_STAGES+1, then saturates; armed is high once it has saturated.
  - Any toggle differences that arrive before armed goes high are absorbed silently, because t_r keeps loading during that window.
- Bus qualification:
  - Each bus bit passes through a SYNC_STAGES chain, giving s_bus.
  - Registers: cand (BUS_WIDTH bits) and cnt (8 bits, saturating at STABLE_CYCLES).
  - When s_bus != cand: cand <= s_bus and cnt <= 0.
  - Otherwise, if cnt < STABLE_CYCLES: cnt <= cnt+1.
  - Update condition: cnt == STABLE_CYCLES, cand != bus_out and bus_hold == 0. When it is met, bus_out <= cand and bus_upd <= 1. In every other cycle bus_upd <= 0.
  - Candidate tracking and cnt continue while bus_hold is high. On hold release, a pending stable value is loaded at the next edge.
  - An s_bus change in the same cycle as an update still updates bus_out with the old cand, then starts a new qualification.
  - bus_busy = (cand != bus_out). It is combinational from registers.

## Timing
- Reset: pktctrl_rstn low at a clock edge clears the following:
  - all sync chains, t_r, armed and the arm counter, lvl_sync and tgl_pulse go to 0;
  - cnt, bus_upd and bus_busy go to 0;
  - cand and bus_out go to INIT_VALUE.
- A reset asserted mid-qualification discards the candidate. No bus_upd is issued for it.
- Latencies, counting edge 1 as the first edge that samples the new input:
  - lvl_sync changes after SYNC_STAGES edges.
  - tgl_pulse is high after SYNC_STAGES+1 edges, for exactly one cycle.
  - bus_out and bus_upd change after SYNC_STAGES+STABLE_CYCLES+2 edges. Example: S=2, K=4 gives 8 edges.
- Toggle events on one channel must be at least 2 cycles apart at the receiver. Two changes closer than this may merge into no pulse or a single pulse; this is a sender obligation and the block does not check it.
- Bus glitch rule: a change of s_bus that lasts fewer than STABLE_CYCLES+1 cycles never reaches bus_out. Returning to the original value yields no bus_upd.
- No combinational path from any input to any output.

## Test plan
- Level channel, SYNC_STAGES=3: raise lvl_in[2] -> lvl_sync[2] rises on the 3rd edge, other bits stay 0.
- Toggle, SYNC_STAGES=2:
  - flip tgl_in[1] 0→1, then after 5 cycles 1→0 -> exactly two single-cycle pulses on tgl_pulse[1], each on the 3rd edge after its flip;
  - hold tgl_in=3'b111 through reset release -> no pulse.
- Bus qualify, S=2, K=4, INIT_VALUE=0: drive bus_in=16'h1234 -> bus_out=16'h1234 with bus_upd high on edge 8; bus_busy high from edge 3 to edge 7.
- Glitch rejection: bus_in 16'h0000→16'hBEEF for 3 cycles →16'h0000 -> bus_out stays 0, bus_upd never asserts, bus_busy pulses during the glitch.
- Hold: bus_hold=1, change bus_in to 16'h00FF, wait 20 cycles -> bus_out unchanged. Then release hold -> bus_out=16'h00FF and bus_upd on the next edge.
- Reset mid-operation: assert pktctrl_rstn=0 for 1 cycle while cnt=2 -> bus_out=INIT_VALUE, no bus_upd. The value still present on bus_in is re-qualified from scratch after reset.
